// File: rtl/usb4_timer_pkg.sv
// Shared types and constants for the USB4 lane timer bank.
package usb4_timer_pkg;

    // Per-channel timer state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } ch_state_e;

    // Default limits (in ticks) for the link training qualifiers
    localparam int unsigned TDISCONNECT_TX   = 50;
    localparam int unsigned TDISCONNECT_RX   = 14;
    localparam int unsigned TCONNECT_RX      = 25;
    localparam int unsigned TDISABLED        = 10;
    localparam int unsigned TTRAINING_ERROR  = 500;
    localparam int unsigned TGEN4_TS1        = 400;
    localparam int unsigned TGEN4_TS2        = 200;

    // Channel assignment used by the training FSM
    localparam int unsigned CH_DISCONNECT_TX  = 0;
    localparam int unsigned CH_DISCONNECT_RX  = 1;
    localparam int unsigned CH_CONNECT_RX     = 2;
    localparam int unsigned CH_DISABLED       = 3;
    localparam int unsigned CH_TRAINING_ERROR = 4;
    localparam int unsigned CH_GEN4_TS1       = 5;
    localparam int unsigned CH_GEN4_TS2       = 6;
    localparam int unsigned NUM_TRAIN_CH      = 7;

endpackage

// File: rtl/timer_channel.sv
// One timeout channel: IDLE/RUN/EXPIRED FSM, counter, live limit compare.
module timer_channel
    import usb4_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o,
    output logic             pulse_o,
    output logic [CNT_W-1:0] count_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic             pulse_q, pulse_d;

    logic [CNT_W:0]   next_w;
    logic             hit_c;

    // Extra MSB on the increment detects saturation; limit 0 disables expiry
    assign next_w = {1'b0, count_q} + (CNT_W+1)'(1);
    assign hit_c  = (limit_i != '0) && (next_w >= {1'b0, limit_i});

    // Next-state and output logic; clear dominates everything
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        periodic_d = periodic_q;
        expired_d  = expired_q;
        pulse_d    = 1'b0;

        case (state_q)
            IDLE: begin
                count_d   = '0;
                expired_d = 1'b0;
                if (run_i) begin
                    state_d    = RUN;
                    periodic_d = periodic_i;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tick_i) begin
                    if (hit_c) begin
                        pulse_d = 1'b1;
                        if (periodic_q) begin
                            count_d = '0;
                        end else begin
                            count_d   = limit_i;
                            expired_d = 1'b1;
                            state_d   = EXPIRED;
                        end
                    end else if (next_w[CNT_W]) begin
                        count_d = '1;
                    end else begin
                        count_d = next_w[CNT_W-1:0];
                    end
                end
            end
            EXPIRED: begin
                if (!run_i) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    expired_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                count_d   = '0;
                expired_d = 1'b0;
            end
        endcase

        if (clr_i) begin
            state_d   = IDLE;
            count_d   = '0;
            expired_d = 1'b0;
            pulse_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
            pulse_q    <= pulse_d;
        end
    end

    assign expired_o = expired_q;
    assign pulse_o   = pulse_q;
    assign count_o   = count_q;

endmodule

// File: rtl/lane_timer_bank.sv
// Bank of independent timeout timers sharing one prescaled tick.
module lane_timer_bank #(
    parameter int unsigned NUM_CH     = 7,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                    sb_clk,
    input  logic                    rst,
    input  logic [PRESCALE_W-1:0]   tick_div,
    input  logic [NUM_CH-1:0]       ch_run,
    input  logic [NUM_CH-1:0]       ch_clr,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [NUM_CH*CNT_W-1:0] ch_limit,
    output logic [NUM_CH-1:0]       ch_expired,
    output logic [NUM_CH-1:0]       ch_pulse,
    output logic [NUM_CH*CNT_W-1:0] ch_count
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_c;

    // Tick on terminal count; wrap silently if tick_div drops below presc
    assign tick_c  = (presc_q == tick_div);
    assign presc_d = (presc_q >= tick_div) ? '0 : presc_q + PRESCALE_W'(1);

    // Free-running prescaler
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i      (sb_clk),
            .rst_i      (rst),
            .tick_i     (tick_c),
            .run_i      (ch_run[i]),
            .clr_i      (ch_clr[i]),
            .periodic_i (ch_periodic[i]),
            .limit_i    (ch_limit[i*CNT_W +: CNT_W]),
            .expired_o  (ch_expired[i]),
            .pulse_o    (ch_pulse[i]),
            .count_o    (ch_count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_lane_timer_bank.sv
// Directed self-checking bench for lane_timer_bank.
module tb_lane_timer_bank;
    import usb4_timer_pkg::*;

    localparam int unsigned NUM_CH     = 7;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned PRESCALE_W = 8;

    logic                    sb_clk = 1'b0;
    logic                    rst;
    logic [PRESCALE_W-1:0]   tick_div;
    logic [NUM_CH-1:0]       ch_run;
    logic [NUM_CH-1:0]       ch_clr;
    logic [NUM_CH-1:0]       ch_periodic;
    logic [NUM_CH*CNT_W-1:0] ch_limit;
    logic [NUM_CH-1:0]       ch_expired;
    logic [NUM_CH-1:0]       ch_pulse;
    logic [NUM_CH*CNT_W-1:0] ch_count;

    int checks = 0;
    int errors = 0;

    lane_timer_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .tick_div   (tick_div),
        .ch_run     (ch_run),
        .ch_clr     (ch_clr),
        .ch_periodic(ch_periodic),
        .ch_limit   (ch_limit),
        .ch_expired (ch_expired),
        .ch_pulse   (ch_pulse),
        .ch_count   (ch_count)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge sb_clk);
    endtask

    task automatic set_limit(input int ch, input int unsigned val);
        ch_limit[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return ch_count[ch*CNT_W +: CNT_W];
    endfunction

    int          found;
    int          npul;
    int unsigned lim   [NUM_CH];
    int          first [NUM_CH];
    int          np    [NUM_CH];

    initial begin
        rst         = 1'b1;
        tick_div    = '0;
        ch_run      = '1;
        ch_clr      = '0;
        ch_periodic = '0;
        ch_limit    = '0;

        // Reset held with run high
        cyc(3);
        check_eq("rst_expired", 128'(ch_expired), 128'(0));
        check_eq("rst_pulse",   128'(ch_pulse),   128'(0));
        check_eq("rst_count",   128'(ch_count),   128'(0));
        rst = 1'b0;
        cyc(3);
        check_eq("rel_count0", 128'(cnt_of(0)), 128'(2));
        check_eq("rel_count6", 128'(cnt_of(6)), 128'(2));
        ch_run = '0;
        cyc(2);
        check_eq("idle_count", 128'(ch_count), 128'(0));

        // One-shot, limit 14, tick every cycle
        set_limit(1, 14);
        ch_run[1] = 1'b1;
        cyc(14);
        check_eq("os_cnt13",   128'(cnt_of(1)), 128'(13));
        check_eq("os_nopulse", 128'(ch_pulse), 128'(0));
        cyc(1);
        check_eq("os_pulse",   128'(ch_pulse), 128'(7'b0000010));
        check_eq("os_expired", 128'(ch_expired), 128'(7'b0000010));
        check_eq("os_cnt14",   128'(cnt_of(1)), 128'(14));
        cyc(1);
        check_eq("os_pulse_w", 128'(ch_pulse[1]), 128'(0));
        check_eq("os_sticky",  128'(ch_expired[1]), 128'(1));
        check_eq("os_hold",    128'(cnt_of(1)), 128'(14));
        ch_run[1] = 1'b0;
        cyc(1);
        check_eq("os_exp_clr", 128'(ch_expired[1]), 128'(0));
        check_eq("os_cnt_clr", 128'(cnt_of(1)), 128'(0));

        // Periodic, tick_div 3, limit 5: pulse every 20 cycles
        tick_div       = 8'd3;
        set_limit(2, 5);
        ch_periodic[2] = 1'b1;
        ch_run[2]      = 1'b1;
        found          = 0;
        for (int t = 0; t < 60 && found == 0; t++) begin
            cyc(1);
            if (ch_pulse[2]) found = 1;
        end
        check_eq("per_first", 128'(found), 128'(1));
        for (int p = 0; p < 10; p++) begin
            npul = 0;
            repeat (19) begin
                cyc(1);
                if (ch_pulse[2]) npul++;
            end
            check_eq("per_gap", 128'(npul), 128'(0));
            cyc(1);
            check_eq("per_pulse",   128'(ch_pulse[2]), 128'(1));
            check_eq("per_expired", 128'(ch_expired[2]), 128'(0));
        end
        ch_run[2]      = 1'b0;
        ch_periodic[2] = 1'b0;
        tick_div       = '0;
        cyc(2);

        // Abort at count 7 of 25
        set_limit(3, 25);
        ch_run[3] = 1'b1;
        cyc(8);
        check_eq("ab_cnt7", 128'(cnt_of(3)), 128'(7));
        ch_run[3] = 1'b0;
        cyc(1);
        check_eq("ab_cnt0",  128'(cnt_of(3)), 128'(0));
        check_eq("ab_pulse", 128'(ch_pulse[3]), 128'(0));
        npul = 0;
        repeat (30) begin
            cyc(1);
            if (ch_pulse[3]) npul++;
        end
        check_eq("ab_nopulse", 128'(npul), 128'(0));

        // Clear with run high on the expiry cycle
        ch_run[3] = 1'b1;
        cyc(25);
        check_eq("clr_cnt24", 128'(cnt_of(3)), 128'(24));
        ch_clr[3] = 1'b1;
        cyc(1);
        check_eq("clr_pulse",   128'(ch_pulse[3]), 128'(0));
        check_eq("clr_expired", 128'(ch_expired[3]), 128'(0));
        check_eq("clr_cnt0",    128'(cnt_of(3)), 128'(0));
        cyc(1);
        check_eq("clr_idle", 128'(cnt_of(3)), 128'(0));
        ch_clr[3] = 1'b0;
        ch_run[3] = 1'b0;
        cyc(1);

        // Limit 0: saturate at all-ones, never expire
        set_limit(4, 0);
        ch_run[4] = 1'b1;
        npul = 0;
        repeat (70000) begin
            cyc(1);
            if (ch_pulse[4]) npul++;
        end
        check_eq("sat_cnt",     128'(cnt_of(4)), 128'(16'hFFFF));
        check_eq("sat_nopulse", 128'(npul), 128'(0));
        check_eq("sat_expired", 128'(ch_expired[4]), 128'(0));

        // Lower limit 500 -> 100 at count 200
        set_limit(5, 500);
        ch_run[5] = 1'b1;
        cyc(201);
        check_eq("low_cnt200", 128'(cnt_of(5)), 128'(200));
        set_limit(5, 100);
        cyc(1);
        check_eq("low_pulse",   128'(ch_pulse[5]), 128'(1));
        check_eq("low_expired", 128'(ch_expired[5]), 128'(1));
        check_eq("low_cnt",     128'(cnt_of(5)), 128'(100));
        ch_run[4] = 1'b0;
        ch_run[5] = 1'b0;
        cyc(1);
        check_eq("all_idle", 128'(ch_count), 128'(0));

        // All channels with training defaults, started together
        lim[CH_DISCONNECT_TX]  = TDISCONNECT_TX;
        lim[CH_DISCONNECT_RX]  = TDISCONNECT_RX;
        lim[CH_CONNECT_RX]     = TCONNECT_RX;
        lim[CH_DISABLED]       = TDISABLED;
        lim[CH_TRAINING_ERROR] = TTRAINING_ERROR;
        lim[CH_GEN4_TS1]       = TGEN4_TS1;
        lim[CH_GEN4_TS2]       = TGEN4_TS2;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            set_limit(i, lim[i]);
            first[i] = 0;
            np[i]    = 0;
        end
        ch_run = '1;
        for (int t = 1; t <= 510; t++) begin
            cyc(1);
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_pulse[i]) begin
                    np[i]++;
                    if (first[i] == 0) first[i] = t;
                end
            end
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            check_eq($sformatf("multi_first%0d", i), 128'(first[i]), 128'(lim[i] + 1));
            check_eq($sformatf("multi_npul%0d", i),  128'(np[i]), 128'(1));
            check_eq($sformatf("multi_exp%0d", i),   128'(ch_expired[i]), 128'(1));
            check_eq($sformatf("multi_cnt%0d", i),   128'(cnt_of(i)), 128'(lim[i]));
        end

        // Reset mid-operation
        rst = 1'b1;
        cyc(1);
        check_eq("mid_rst_expired", 128'(ch_expired), 128'(0));
        check_eq("mid_rst_count",   128'(ch_count), 128'(0));
        check_eq("mid_rst_pulse",   128'(ch_pulse), 128'(0));
        rst    = 1'b0;
        ch_run = '0;
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
